// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU with valid/ready operand and result handshakes.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier (op 1000).
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             f_zero,
    output logic             f_ovf,
    output logic             f_carry
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [SHW:0] CNT_DONE = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_z;
    logic             r_zero;
    logic             r_ovf;
    logic             r_carry;

    logic             w_accept;
    logic             w_is_add;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic             w_sgn_ovf;
    logic             w_lt;
    logic             w_ltu;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_res_ovf;
    logic             w_res_carry;
    logic             w_def;
    logic             w_res_zero;

    assign w_accept = (r_state == S_IDLE) && in_valid;

    // One adder serves ADD, SUB and both compares (x + ~y + 1 for all but ADD).
    assign w_is_add  = (op == OP_ADD);
    assign w_b       = w_is_add ? y : ~y;
    assign w_sum     = {1'b0, x} + {1'b0, w_b} + {{WIDTH{1'b0}}, ~w_is_add};
    assign w_sgn_ovf = (x[WIDTH-1] == w_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != x[WIDTH-1]);
    assign w_lt      = w_sum[WIDTH-1] ^ w_sgn_ovf;
    assign w_ltu     = ~w_sum[WIDTH];
    assign w_sh      = y[SHW-1:0];

    always_comb begin
        w_res       = '0;
        w_res_ovf   = 1'b0;
        w_res_carry = 1'b0;
        w_def       = 1'b1;
        unique case (op)
            OP_ADD, OP_SUB: begin
                w_res       = w_sum[WIDTH-1:0];
                w_res_ovf   = w_sgn_ovf;
                w_res_carry = w_sum[WIDTH];
            end
            OP_NOT:  w_res = ~x;
            OP_AND:  w_res = x & y;
            OP_OR:   w_res = x | y;
            OP_XOR:  w_res = x ^ y;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
            OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (x == y)};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_ltu};
            OP_SHL:  w_res = x << w_sh;
            OP_SRA:  w_res = $signed(x) >>> w_sh;
            default: w_def = 1'b0;
        endcase
    end

    assign w_res_zero = w_def && (w_res == '0);

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mpl;
    logic [WIDTH-1:0]   r_mcd;
    logic [SHW:0]       r_cnt;
    logic [WIDTH:0]     w_step;
    logic               w_is_mul;

    assign w_is_mul = (op == OP_MUL);

    // Add into the high half, then shift the whole accumulator right by one.
    assign w_step = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                    (r_mpl[0] ? {1'b0, r_mcd} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_mpl <= '0;
            r_mcd <= '0;
            r_cnt <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc <= '0;
            r_mpl <= y;
            r_mcd <= x;
            r_cnt <= '0;
        end else if (r_state == S_BUSY && r_cnt != CNT_DONE) begin
            r_acc <= {w_step, r_acc[WIDTH-1:1]};
            r_mpl <= r_mpl >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    w_next = w_is_mul ? S_BUSY : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            S_BUSY: begin
                if (r_cnt == CNT_DONE) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
        end else if (r_state == S_BUSY && r_cnt == CNT_DONE) begin
            r_z     <= r_acc[WIDTH-1:0];
            r_zero  <= (r_acc[WIDTH-1:0] == '0);
            r_ovf   <= 1'b0;
            r_carry <= |r_acc[2*WIDTH-1:WIDTH];
        end else if (w_accept && !w_is_mul) begin
`else
        end else if (w_accept) begin
`endif
            r_z     <= w_res;
            r_zero  <= w_res_zero;
            r_ovf   <= w_res_ovf;
            r_carry <= w_res_carry;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign z         = r_z;
    assign f_zero    = r_zero;
    assign f_ovf     = r_ovf;
    assign f_carry   = r_carry;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu (WIDTH=8) against an arithmetic model.
// Build with SEQ_ALU_MUL_EN defined to exercise the multiplier path.
module tb_seq_alu;

    localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [3:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] z;
    logic         f_zero;
    logic         f_ovf;
    logic         f_carry;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x(x),
        .y(y),
        .op(op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z(z),
        .f_zero(f_zero),
        .f_ovf(f_ovf),
        .f_carry(f_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Reference results from plain integer arithmetic on the op definitions.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] rz,
                                  output logic rzf, output logic rof,
                                  output logic rcf);
        int ua, ub, sa, sb, r, sh;
        bit def;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        sh = ub % W;
        r = 0;
        def = 1'b1;
        rof = 1'b0;
        rcf = 1'b0;
        case (o)
            4'd0: begin
                r = ua + ub;
                rcf = (r > 255);
                rof = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd1: begin
                r = ua - ub;
                rcf = (ua >= ub);
                rof = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd2: r = 255 - ua;
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = (sa < sb) ? 1 : 0;
            4'd7: r = (ua == ub) ? 1 : 0;
            4'd8: begin
                r = MUL_EN ? ua * ub : 0;
                rcf = MUL_EN && (r > 255);
                def = MUL_EN;
            end
            4'd9: r = (ua < ub) ? 1 : 0;
            4'd10: r = ua * (1 << sh);
            4'd11: r = sa >>> sh;
            default: def = 1'b0;
        endcase
        rz = r[W-1:0];
        rzf = def && (rz == 0);
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold,
                          input string tag);
        logic [W-1:0] ez;
        logic ezf, eof, ecf;
        int lat, elat;
        model(o, a, b, ez, ezf, eof, ecf);
        elat = (o == 4'd8 && MUL_EN) ? W + 1 : 1;
        chk({tag, "/in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        x = a;
        y = b;
        op = o;
        @(negedge clk);
        in_valid = 1'b0;
        x = W'($urandom);
        y = W'($urandom);
        op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, lat, elat);
        chk({tag, "/z"}, z, ez);
        chk({tag, "/flags"}, {f_zero, f_ovf, f_carry}, {ezf, eof, ecf});
        repeat (hold) @(negedge clk);
        chk({tag, "/z_hold"}, {out_valid, z}, {1'b1, ez});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/release"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [W-1:0] ez;
        logic ezf, eof, ecf;

        #2 rst_n = 1'b0;
        #1;
        chk("reset/outputs", {out_valid, z, f_zero, f_ovf, f_carry}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset/in_ready", in_ready, 1);

        run_op(4'd0, 8'h7F, 8'h01, 0, "add_ovf");
        run_op(4'd1, 8'h05, 8'h05, 1, "sub_zero");
        run_op(4'd1, 8'h80, 8'h01, 0, "sub_ovf");
        run_op(4'd6, 8'hFF, 8'h01, 0, "slt");
        run_op(4'd6, 8'h80, 8'h7F, 0, "slt_ovf");
        run_op(4'd9, 8'hFF, 8'h01, 0, "sltu");
        run_op(4'd11, 8'h90, 8'h02, 0, "sra");
        run_op(4'd10, 8'h81, 8'h0B, 0, "shl");
        run_op(4'd7, 8'h5A, 8'h5A, 0, "eq");
        run_op(4'd8, 8'd13, 8'd11, 0, "mul_13x11");
        run_op(4'd8, 8'h10, 8'h10, 2, "mul_carry");
        run_op(4'd13, 8'hFF, 8'hFF, 0, "undef");

        // Backpressure: held result must not move and new operands are refused.
        model(4'd0, 8'h22, 8'h33, ez, ezf, eof, ecf);
        in_valid = 1'b1;
        x = 8'h22;
        y = 8'h33;
        op = 4'd0;
        @(negedge clk);
        x = 8'h01;
        y = 8'h01;
        op = 4'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp/hold", {out_valid, in_ready, z, f_zero, f_ovf, f_carry},
                {1'b1, 1'b0, ez, ezf, eof, ecf});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp/to_idle", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp/next_op", {out_valid, z, f_zero, f_carry}, {1'b1, 8'h00, 1'b1, 1'b1});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        run_op(4'd0, 8'h40, 8'h02, 0, "pre_rst");
        in_valid = 1'b1;
        x = 8'd13;
        y = 8'd11;
        op = 4'd8;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/before", {out_valid, z}, {!MUL_EN, (MUL_EN ? 8'h42 : 8'h00)});
        #2 rst_n = 1'b0;
        #1;
        chk("rst/async", {out_valid, z, f_zero, f_ovf, f_carry}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/after", {in_ready, out_valid}, 2'b10);
        run_op(4'd0, 8'd3, 8'd4, 0, "post_rst_add");

        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                   $urandom_range(0, 2), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
